dpwm_gate_driver: RTL and testbench
===================================

# dpwm_gate_driver

Digital PWM back end for the SMPS control loop. Takes the 10-bit duty command from the compensator and produces complementary high-side and low-side gate signals with programmable dead time. Also emits the once-per-period sample strobe that paces the ADC and the compensator's enable. Sits between the compensator output and the power-stage gate drivers.

## Interface
- DW, 10: duty/counter width; switching period = 2^DW clk cycles
- DEAD, 4: dead time in clk cycles (legal range 1..15)
- DMAX, 1000: maximum duty; larger commands are clamped to DMAX
- DMIN, 8: minimum non-zero duty; commands below DMIN become 0
- SAMPLE_PT, 512: counter value that triggers sample_en

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  run enable; 0 forces both gates off
- duty_in  in  DW  unsigned duty command (compensator output)
- duty_valid  in  1  loads duty_in into the shadow register
- gate_hi  out  1  high-side gate
- gate_lo  out  1  low-side gate
- sample_en  out  1  one-cycle pulse per period (ADC/compensator enable)
- period_start  out  1  one-cycle pulse at the start of each period

## Operation
- Period counter cnt (DW bits):
  - When en=1, increments every cycle and wraps 2^DW-1 -> 0.
  - When en=0, held at 0.
- Shadow register d_sh loads duty_in whenever duty_valid=1.
- Active duty d_act loads clamp(d_sh) when en=1 and cnt=2^DW-1, and on every cycle while en=0.
  - clamp(x) = DMAX if x>DMAX; 0 if x<DMIN; otherwise x.
  - If duty_valid coincides with a load cycle, d_act takes the old d_sh. The new value applies one period later.
- Raw PWM: raw = (cnt < d_act), computed from registered values.
- Gate FSM (Moore; gates decoded from the state register). States: IDLE, HI, DT_LO, LO, DT_HI.
  - IDLE: both gates 0. If en=1, go to HI if raw=1, otherwise LO.
  - HI: gate_hi=1. If raw=0, go to DT_LO and clear the dead-time counter.
  - DT_LO: both gates 0 for exactly DEAD cycles. On expiry, go to HI if raw=1, otherwise LO.
  - LO: gate_lo=1. If raw=1, go to DT_HI and clear the dead-time counter.
  - DT_HI: both gates 0 for exactly DEAD cycles. On expiry, go to HI if raw=1, otherwise LO.
  - en=0 in any state: IDLE on the next cycle.
- Invariant: gate_hi and gate_lo are never 1 in the same cycle. Every HI<->LO change passes through at least DEAD cycles with both gates 0.
- sample_en: registered, high for one cycle following any cycle with en=1 and cnt=SAMPLE_PT.
- period_start: registered, high for one cycle following any cycle with en=1 and cnt=0.

## Timing
- Reset values: gate_hi=0, gate_lo=0, sample_en=0, period_start=0, cnt=0, d_sh=0, d_act=0, FSM=IDLE, dead-time counter=0.
- Reset asserted mid-period forces all of the above on the next edge, regardless of en.
- Gate latency: one cycle from a change in raw to the FSM state change.
- Steady state with d_act=D (D>=DMIN) and DEAD=T, per period:
  - gate_hi high for D-T cycles
  - gate_lo high for 2^DW-D-T cycles
  - 2T cycles with both gates low
- If a pulse is shorter than DEAD, raw falls during DT_HI and the FSM goes to LO on expiry. No high-side pulse is produced.
- Command update latency: from duty_valid to the new d_act is at most one full period plus one cycle.
- d_act=0: FSM stays in LO; gate_hi is never asserted.

## Test plan
- Reset release, en=1, duty_in=100 with duty_valid from the first cycle, DEAD=4 -> from the second period onward, gate_hi high exactly 96 cycles and gate_lo high exactly 920 cycles per 1024-cycle period; never both high.
- duty_in=1023 -> clamped: gate_hi high 996 cycles per period. duty_in=5 -> gate_hi never asserted, gate_lo high continuously.
- duty_valid pulsed at cnt=2^DW-1 with 300 (previous value 100) -> the following period still uses 100; the period after uses 300.
- en dropped mid-HI -> both gates 0 on the next cycle and cnt=0. en raised again with duty 200 -> gate_hi goes high one cycle after restart, with no dead-time wait from IDLE.
- sample_en and period_start -> each is exactly one pulse per period, 512 cycles apart, and absent while en=0.
- rst asserted while in DT_HI -> all outputs 0 on the next cycle. After release, behaviour is identical to the power-up sequence.

Source files
------------

// File: rtl/dpwm_gate_driver.sv
// Digital PWM back end: period counter, double-buffered duty command,
// complementary gate FSM with dead time, and per-period sample/start strobes.
module dpwm_gate_driver #(
  parameter int unsigned DW        = 10,
  parameter int unsigned DEAD      = 4,
  parameter int unsigned DMAX      = 1000,
  parameter int unsigned DMIN      = 8,
  parameter int unsigned SAMPLE_PT = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] duty_in,
  input  logic          duty_valid,
  output logic          gate_hi,
  output logic          gate_lo,
  output logic          sample_en,
  output logic          period_start
);

  localparam int unsigned   DtW      = 4;
  localparam logic [DW-1:0] CntLast  = '1;
  localparam logic [DW-1:0] DmaxW    = DW'(DMAX);
  localparam logic [DW-1:0] DminW    = DW'(DMIN);
  localparam logic [DW-1:0] SampleW  = DW'(SAMPLE_PT);
  localparam logic [DtW-1:0] DtLast  = DtW'(DEAD - 1);

  typedef enum logic [2:0] {StIdle, StHi, StDtLo, StLo, StDtHi} state_e;

  logic [DW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  d_sh_q, d_sh_d;
  logic [DW-1:0]  d_act_q, d_act_d;
  logic [DW-1:0]  d_clamp;
  logic [DtW-1:0] dt_q, dt_d;
  state_e         state_q, state_d;
  logic           gate_hi_q, gate_hi_d;
  logic           gate_lo_q, gate_lo_d;
  logic           sample_en_q, sample_en_d;
  logic           period_start_q, period_start_d;
  logic           raw;

  // Raw PWM compare uses only registered values so it is glitch-free into the FSM.
  assign raw = (cnt_q < d_act_q);

  // Counter, shadow/active duty and strobe next-state.
  always_comb begin
    cnt_d = en ? cnt_q + DW'(1) : '0;

    d_sh_d = duty_valid ? duty_in : d_sh_q;

    d_clamp = d_sh_q;
    if (d_sh_q > DmaxW) begin
      d_clamp = DmaxW;
    end else if (d_sh_q < DminW) begin
      d_clamp = '0;
    end

    // Active duty only moves at the period boundary (or freely while stopped),
    // so a command landing on the load cycle takes effect one period later.
    d_act_d = d_act_q;
    if (!en || (cnt_q == CntLast)) begin
      d_act_d = d_clamp;
    end

    sample_en_d    = en && (cnt_q == SampleW);
    period_start_d = en && (cnt_q == '0);
  end

  // Gate FSM next-state; every HI<->LO change is routed through a dead-time state.
  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    if (!en) begin
      state_d = StIdle;
      dt_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = raw ? StHi : StLo;
        StHi: begin
          if (!raw) begin
            state_d = StDtLo;
            dt_d    = '0;
          end
        end
        StLo: begin
          if (raw) begin
            state_d = StDtHi;
            dt_d    = '0;
          end
        end
        StDtLo, StDtHi: begin
          if (dt_q == DtLast) begin
            state_d = raw ? StHi : StLo;
          end else begin
            dt_d = dt_q + DtW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
    // Gates are decoded from the next state and registered alongside it.
    gate_hi_d = (state_d == StHi);
    gate_lo_d = (state_d == StLo);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      d_sh_q         <= '0;
      d_act_q        <= '0;
      sample_en_q    <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      d_sh_q         <= d_sh_d;
      d_act_q        <= d_act_d;
      sample_en_q    <= sample_en_d;
      period_start_q <= period_start_d;
    end
  end

  // FSM state, dead-time counter and registered gate outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      dt_q      <= '0;
      gate_hi_q <= 1'b0;
      gate_lo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dt_q      <= dt_d;
      gate_hi_q <= gate_hi_d;
      gate_lo_q <= gate_lo_d;
    end
  end

  assign gate_hi      = gate_hi_q;
  assign gate_lo      = gate_lo_q;
  assign sample_en    = sample_en_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_dpwm_gate_driver.sv
// Self-checking bench for dpwm_gate_driver: per-period window statistics are
// queued as expectations when a command is driven and popped when measured.
module tb_dpwm_gate_driver;

  localparam int Period = 1024;

  logic       clk;
  logic       rst;
  logic       en;
  logic [9:0] duty_in;
  logic       duty_valid;
  logic       gate_hi;
  logic       gate_lo;
  logic       sample_en;
  logic       period_start;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    int hi;
    int lo;
    int both;
    int ps;
    int se;
    int gap;
  } win_t;

  win_t exp_q[$];

  dpwm_gate_driver dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .gate_hi      (gate_hi),
    .gate_lo      (gate_lo),
    .sample_en    (sample_en),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if something wedges.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic win_t mk(input int hi, input int lo);
    win_t w;
    w.hi   = hi;
    w.lo   = lo;
    w.both = 0;
    w.ps   = 1;
    w.se   = 1;
    w.gap  = 512;
    return w;
  endfunction

  function automatic string fmt(input win_t w);
    return $sformatf("hi=%0d lo=%0d both=%0d ps=%0d se=%0d gap=%0d",
                     w.hi, w.lo, w.both, w.ps, w.se, w.gap);
  endfunction

  // Collect gate/strobe statistics over one full-period window.
  task automatic measure(output win_t w);
    int ps_idx;
    int se_idx;
    w      = '0;
    ps_idx = -1;
    se_idx = -1;
    for (int i = 0; i < Period; i++) begin
      tick();
      if (gate_hi === 1'b1) w.hi = w.hi + 1;
      if (gate_lo === 1'b1) w.lo = w.lo + 1;
      if (gate_hi === 1'b1 && gate_lo === 1'b1) w.both = w.both + 1;
      if (period_start === 1'b1) begin
        w.ps   = w.ps + 1;
        ps_idx = i;
      end
      if (sample_en === 1'b1) begin
        w.se   = w.se + 1;
        se_idx = i;
      end
    end
    if (ps_idx >= 0 && se_idx >= 0) w.gap = (se_idx - ps_idx + Period) % Period;
    else w.gap = -1;
  endtask

  task automatic wait_ps(input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (period_start !== 1'b1 && k < 2 * Period + 8);
    if (period_start !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_ps_timeout: got no period_start in %0d cycles, required one", tag, k);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    en         = 1'b1;
    duty_in    = 10'd100;
    duty_valid = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({gate_hi, gate_lo, sample_en, period_start} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 0000",
               {gate_hi, gate_lo, sample_en, period_start});
    end
    n_tests++;
    if (dut.cnt_q !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d, required 0", dut.cnt_q);
    end
    n_tests++;
    if (dut.d_act_q !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_d_act: got %0d, required 0", dut.d_act_q);
    end
  endtask

  // Release from reset with en=1 and duty 100 valid from the first cycle.
  task automatic test_power_up(input string tag);
    win_t obs;
    win_t expd;
    en         = 1'b1;
    duty_in    = 10'd100;
    duty_valid = 1'b1;
    exp_q.push_back(mk(0, 1024));  // first period still runs on the reset duty of 0
    exp_q.push_back(mk(96, 920));
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      measure(obs);
      expd = exp_q.pop_front();
      n_tests++;
      if (obs !== expd) begin
        n_fail++;
        $display("FAIL %s_period%0d: got %s, required %s", tag, w + 1, fmt(obs), fmt(expd));
      end
    end
    duty_valid = 1'b0;
  endtask

  task automatic test_clamp();
    win_t obs;
    win_t expd;
    int   duties[2];
    int   his[2];
    duties = '{1023, 5};
    his    = '{996, 0};
    for (int c = 0; c < 2; c++) begin
      duty_in    = 10'(duties[c]);
      duty_valid = 1'b1;
      exp_q.push_back(mk(his[c], Period - his[c] - (his[c] != 0 ? 8 : 0)));
      tick();
      duty_valid = 1'b0;
      repeat (2 * Period) tick();
      measure(obs);
      expd = exp_q.pop_front();
      n_tests++;
      if (obs !== expd) begin
        n_fail++;
        $display("FAIL clamp_duty%0d: got %s, required %s", duties[c], fmt(obs), fmt(expd));
      end
    end
  endtask

  // A command landing on the load cycle must wait one more period.
  task automatic test_cmd_latency();
    win_t obs;
    win_t expd;
    duty_in    = 10'd100;
    duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    repeat (2 * Period) tick();
    wait_ps("latency");
    repeat (Period - 2) tick();  // now in the cnt=1023 cycle
    duty_in    = 10'd300;
    duty_valid = 1'b1;
    exp_q.push_back(mk(96, 920));
    exp_q.push_back(mk(296, 720));
    tick();
    duty_valid = 1'b0;
    for (int w = 0; w < 2; w++) begin
      measure(obs);
      expd = exp_q.pop_front();
      n_tests++;
      if (obs !== expd) begin
        n_fail++;
        $display("FAIL latency_period%0d: got %s, required %s", w + 1, fmt(obs), fmt(expd));
      end
    end
  endtask

  task automatic test_en_drop();
    int bad = 0;
    wait_ps("en_drop");
    repeat (50) tick();
    n_tests++;
    if (gate_hi !== 1'b1) begin
      n_fail++;
      $display("FAIL en_drop_pre_hi: got gate_hi=%b, required 1", gate_hi);
    end
    en         = 1'b0;
    duty_in    = 10'd200;
    duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    n_tests++;
    if ({gate_hi, gate_lo} !== 2'b00) begin
      n_fail++;
      $display("FAIL en_drop_gates: got %b, required 00", {gate_hi, gate_lo});
    end
    n_tests++;
    if (dut.cnt_q !== 10'd0) begin
      n_fail++;
      $display("FAIL en_drop_cnt: got %0d, required 0", dut.cnt_q);
    end
    for (int i = 0; i < 600; i++) begin
      tick();
      if ((gate_hi | gate_lo | sample_en | period_start) !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL en_off_quiet: got %0d active cycles, required 0", bad);
    end
    en = 1'b1;
    tick();
    n_tests++;
    if ({gate_hi, gate_lo} !== 2'b10) begin
      n_fail++;
      $display("FAIL restart_hi: got hi/lo=%b, required 10", {gate_hi, gate_lo});
    end
    n_tests++;
    if (period_start !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_ps: got %b, required 1", period_start);
    end
  endtask

  task automatic test_rst_dt_hi();
    int bad = 0;
    wait_ps("rst_dt");  // cnt=1: FSM is in the high-side dead time
    n_tests++;
    if ({gate_hi, gate_lo} !== 2'b00) begin
      n_fail++;
      $display("FAIL dt_hi_gates: got %b, required 00", {gate_hi, gate_lo});
    end
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if ({gate_hi, gate_lo, sample_en, period_start} !== 4'b0000 || dut.cnt_q !== 10'd0) begin
      n_fail++;
      $display("FAIL rst_in_dt: got outs=%b cnt=%0d, required 0000 and 0",
               {gate_hi, gate_lo, sample_en, period_start}, dut.cnt_q);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if ((gate_hi | gate_lo | sample_en | period_start) !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rst_hold_quiet: got %0d active cycles, required 0", bad);
    end
    test_power_up("rerun");
  endtask

  initial begin
    test_reset();
    test_power_up("pwrup");
    test_clamp();
    test_cmd_latency();
    test_en_drop();
    test_rst_dt_hi();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
